mul_operand_sequencer: RTL

//  Upstream front-end for the repeated-addition multiplier (datapath + controller pair).
//  - Accepts an operand pair {a,b} on a valid/ready input.
//  - Serialises the pair onto the multiplier's shared data_in bus and pulses start.
//  - Waits for done, captures the product and presents it on a valid/ready output.
//  - Counts cycles spent inside the multiplier, for throughput profiling.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_busy_counter.sv | 34 +++
 rtl/mul_operand_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the repeated-addition multiplier front-end.
package mul_pkg;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned CNT_WIDTH_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LDA   = 3'd2,
        S_LDB   = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

endpackage

// File: rtl/mul_busy_counter.sv
// Saturating busy-cycle counter with synchronous clear and count enable.
// Exposes the value the counter takes at the next edge, so the cycle that is being counted is included.
module mul_busy_counter
    import mul_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count_next
);

    logic [CNT_WIDTH-1:0] count;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != '1)) begin
            count_next = count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Serialises an operand pair onto the multiplier data_in bus, waits for done and returns the product.
// Optional ZERO_BYPASS_EN: pairs with a zero operand skip the multiplier and return 0 directly.
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_data,
    input  logic                 mul_done,
    input  logic [WIDTH-1:0]     mul_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_product,
    output logic [CNT_WIDTH-1:0] out_cycles
);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 accept;
    logic                 zero_pair;
    logic                 finish;

    assign accept = (state == S_IDLE) && in_valid;
    assign finish = (state == S_WAIT) && mul_done;

`ifdef ZERO_BYPASS_EN
    assign zero_pair = (in_a == '0) || (in_b == '0);
`else
    assign zero_pair = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = zero_pair ? S_OUT : S_START;
            S_START: state_next = S_LDA;
            S_LDA:   state_next = S_LDB;
            S_LDB:   state_next = S_WAIT;
            S_WAIT:  if (mul_done) state_next = S_OUT;
            S_OUT:   if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            out_product <= '0;
            out_cycles  <= '0;
        end else begin
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
                if (zero_pair) begin
                    out_product <= '0;
                    out_cycles  <= '0;
                end
            end
            if (finish) begin
                out_product <= mul_product;
                out_cycles  <= cnt_next;
            end
        end
    end

    always_comb begin
        mul_data = '0;
        case (state)
            S_START, S_LDA: mul_data = a_q;
            S_LDB, S_WAIT:  mul_data = b_q;
            default:        mul_data = '0;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign mul_start = (state == S_START);
    assign out_valid = (state == S_OUT);

    mul_busy_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_busy_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == S_LDB),
        .enable     (state == S_WAIT),
        .count_next (cnt_next)
    );

endmodule
